// File: rtl/setpoints_pkg.sv
// Shared constants and value tables for the setpoint memory.
// Every table entry is a value the 7-segment encoder downstream can display.
package setpoints_pkg;

  localparam int W_FREC = 8;
  localparam int W_CORR = 10;
  localparam int W_IDX  = 5;

  localparam logic [W_IDX-1:0] IDX_F_MAX = 5'd9;
  localparam logic [W_IDX-1:0] IDX_C_MAX = 5'd20;

  function automatic logic [W_FREC-1:0] tabla_f(input logic [W_IDX-1:0] idx);
    logic [W_FREC-1:0] valor;
    case (idx)
      5'd0:    valor = 8'd0;
      5'd1:    valor = 8'd30;
      5'd2:    valor = 8'd50;
      5'd3:    valor = 8'd75;
      5'd4:    valor = 8'd100;
      5'd5:    valor = 8'd125;
      5'd6:    valor = 8'd150;
      5'd7:    valor = 8'd175;
      5'd8:    valor = 8'd200;
      5'd9:    valor = 8'd250;
      default: valor = 8'd0;
    endcase
    return valor;
  endfunction

  // Current table is a uniform 50-unit ramp, so it is computed rather than listed.
  function automatic logic [W_CORR-1:0] tabla_c(input logic [W_IDX-1:0] idx);
    logic [W_CORR-1:0] idx_ext;
    idx_ext = {{(W_CORR-W_IDX){1'b0}}, idx};
    return idx_ext * 10'd50;
  endfunction

endpackage

// File: rtl/memoria_setpoints_if.sv
// Button inputs and setpoint outputs of memoria_setpoints, bundled as one interface.
interface memoria_setpoints_if;
  import setpoints_pkg::*;

  logic              btn_up;
  logic              btn_down;
  logic              btn_modo;
  logic [W_FREC-1:0] frecuencia;
  logic [W_CORR-1:0] corriente;
  logic              control;
  logic              cambio;

  modport slave (
    input  btn_up, btn_down, btn_modo,
    output frecuencia, corriente, control, cambio
  );

  modport master (
    output btn_up, btn_down, btn_modo,
    input  frecuencia, corriente, control, cambio
  );
endinterface

// File: rtl/antirrebote.sv
// One push-button: 2-FF synchronizer, debounce counter and rising-edge pulse.
// A level already held when reset releases is ignored until it is seen released.
module antirrebote #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk_d,
  input  logic reset,
  input  logic boton,
`ifdef AUTORREPETICION_EN
  output logic nivel,
`endif
  output logic pulso
);
  localparam int W_CNT = $clog2(DEBOUNCE_CYCLES);
  localparam logic [W_CNT-1:0] CNT_FIN = W_CNT'(DEBOUNCE_CYCLES - 1);

  logic             sinc1_reg, sinc2_reg;
  logic             vld1_reg, vld2_reg;
  logic             nivel_reg, armado_reg, pulso_reg;
  logic [W_CNT-1:0] cnt_reg;

  always_ff @(posedge clk_d or posedge reset) begin
    if (reset) begin
      sinc1_reg  <= 1'b0;
      sinc2_reg  <= 1'b0;
      vld1_reg   <= 1'b0;
      vld2_reg   <= 1'b0;
      nivel_reg  <= 1'b0;
      armado_reg <= 1'b0;
      pulso_reg  <= 1'b0;
      cnt_reg    <= '0;
    end else begin
      sinc1_reg <= boton;
      sinc2_reg <= sinc1_reg;
      vld1_reg  <= 1'b1;
      vld2_reg  <= vld1_reg;
      pulso_reg <= 1'b0;
      // Arm only once a real released sample has crossed the synchronizer.
      if (vld2_reg && !sinc2_reg && !nivel_reg)
        armado_reg <= 1'b1;
      if (!vld2_reg || (sinc2_reg == nivel_reg)) begin
        cnt_reg <= '0;
      end else if (cnt_reg == CNT_FIN) begin
        nivel_reg <= sinc2_reg;
        pulso_reg <= sinc2_reg & armado_reg;
        cnt_reg   <= '0;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

`ifdef AUTORREPETICION_EN
  assign nivel = nivel_reg & armado_reg;
`endif
  assign pulso = pulso_reg;

endmodule

// File: rtl/memoria_setpoints.sv
// Push-button setpoint memory feeding the 7-segment encoder of the DPWM design.
// Optional auto-repeat of held up/down buttons is enabled by defining AUTORREPETICION_EN.
module memoria_setpoints
  import setpoints_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int HOLD_CYCLES     = 256,
  parameter int REPEAT_CYCLES   = 64
) (
  input  logic                 clk_d,
  input  logic                 reset,
  memoria_setpoints_if.slave   bus
);
  logic [2:0] boton;
  logic [2:0] pulso;
  logic       sube, baja;

  logic [W_IDX-1:0]  idx_f_reg, idx_f_next;
  logic [W_IDX-1:0]  idx_c_reg, idx_c_next;
  logic [W_FREC-1:0] frec_reg, frec_next;
  logic [W_CORR-1:0] corr_reg, corr_next;
  logic              control_reg, control_next;
  logic              cambio_reg, cambio_next;

  // Bit 0 = up, bit 1 = down, bit 2 = mode.
  assign boton = {bus.btn_modo, bus.btn_down, bus.btn_up};

`ifdef AUTORREPETICION_EN
  logic [2:0] nivel;
`endif

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_boton
      antirrebote #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_antirrebote (
        .clk_d (clk_d),
        .reset (reset),
        .boton (boton[gi]),
`ifdef AUTORREPETICION_EN
        .nivel (nivel[gi]),
`endif
        .pulso (pulso[gi])
      );
    end
  endgenerate

`ifdef AUTORREPETICION_EN
  localparam int REP_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int W_REP   = $clog2(REP_MAX + 1);
  localparam logic [W_REP-1:0] REP_HOLD_FIN = W_REP'(HOLD_CYCLES - 1);
  localparam logic [W_REP-1:0] REP_PER_FIN  = W_REP'(REPEAT_CYCLES - 1);

  logic [W_REP-1:0] rep_cnt_reg;
  logic             repitiendo_reg, rep_pulso_reg;

  // Only a single held direction repeats; release or both held restarts the hold delay.
  always_ff @(posedge clk_d or posedge reset) begin
    if (reset) begin
      rep_cnt_reg    <= '0;
      repitiendo_reg <= 1'b0;
      rep_pulso_reg  <= 1'b0;
    end else begin
      rep_pulso_reg <= 1'b0;
      if (!(nivel[0] ^ nivel[1])) begin
        rep_cnt_reg    <= '0;
        repitiendo_reg <= 1'b0;
      end else if (rep_cnt_reg == (repitiendo_reg ? REP_PER_FIN : REP_HOLD_FIN)) begin
        rep_cnt_reg    <= '0;
        repitiendo_reg <= 1'b1;
        rep_pulso_reg  <= 1'b1;
      end else begin
        rep_cnt_reg <= rep_cnt_reg + 1'b1;
      end
    end
  end

  assign sube = pulso[0] | (rep_pulso_reg & nivel[0]);
  assign baja = pulso[1] | (rep_pulso_reg & nivel[1]);
`else
  assign sube = pulso[0];
  assign baja = pulso[1];
`endif

  // The step targets the mode held in control_reg, so a simultaneous mode press
  // steps the old mode and toggles in the same cycle.
  always_comb begin
    idx_f_next   = idx_f_reg;
    idx_c_next   = idx_c_reg;
    control_next = control_reg ^ pulso[2];
    if (sube && !baja) begin
      if (control_reg) begin
        if (idx_f_reg != IDX_F_MAX) idx_f_next = idx_f_reg + 1'b1;
      end else begin
        if (idx_c_reg != IDX_C_MAX) idx_c_next = idx_c_reg + 1'b1;
      end
    end else if (baja && !sube) begin
      if (control_reg) begin
        if (idx_f_reg != '0) idx_f_next = idx_f_reg - 1'b1;
      end else begin
        if (idx_c_reg != '0) idx_c_next = idx_c_reg - 1'b1;
      end
    end
    frec_next   = tabla_f(idx_f_next);
    corr_next   = tabla_c(idx_c_next);
    cambio_next = (frec_next != frec_reg) || (corr_next != corr_reg) ||
                  (control_next != control_reg);
  end

  always_ff @(posedge clk_d or posedge reset) begin
    if (reset) begin
      idx_f_reg   <= '0;
      idx_c_reg   <= '0;
      frec_reg    <= '0;
      corr_reg    <= '0;
      control_reg <= 1'b1;
      cambio_reg  <= 1'b0;
    end else begin
      idx_f_reg   <= idx_f_next;
      idx_c_reg   <= idx_c_next;
      frec_reg    <= frec_next;
      corr_reg    <= corr_next;
      control_reg <= control_next;
      cambio_reg  <= cambio_next;
    end
  end

  assign bus.frecuencia = frec_reg;
  assign bus.corriente  = corr_reg;
  assign bus.control    = control_reg;
  assign bus.cambio     = cambio_reg;

endmodule

// File: tb/tb_memoria_setpoints.sv
// Randomized self-checking bench for memoria_setpoints against a table/index model.
module tb_memoria_setpoints;
  localparam int DEB  = 4;
  localparam int HOLD = 8;
  localparam int REP  = 4;

  logic clk_d = 1'b0;
  logic reset = 1'b1;
  always #5 clk_d = ~clk_d;

  memoria_setpoints_if bus();

  memoria_setpoints #(
    .DEBOUNCE_CYCLES(DEB),
    .HOLD_CYCLES(HOLD),
    .REPEAT_CYCLES(REP)
  ) dut (
    .clk_d (clk_d),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cambio_cnt;

  // Reference model: indices into the value lists plus the mode bit.
  int tab_f[10] = '{0, 30, 50, 75, 100, 125, 150, 175, 200, 250};
  int m_f, m_c;
  bit m_ctl;

  function automatic int exp_f();
    return tab_f[m_f];
  endfunction

  function automatic int exp_c();
    return m_c * 50;
  endfunction

  function automatic void modelo_reset();
    m_f = 0; m_c = 0; m_ctl = 1'b1;
  endfunction

  // Applies one set of simultaneous presses; returns 1 if any output value changes.
  function automatic bit modelo(input bit u, input bit d, input bit m);
    int of, oc;
    bit octl;
    of = exp_f(); oc = exp_c(); octl = m_ctl;
    if (u && !d) begin
      if (m_ctl) m_f = (m_f < 9) ? m_f + 1 : 9;
      else       m_c = (m_c < 20) ? m_c + 1 : 20;
    end else if (d && !u) begin
      if (m_ctl) m_f = (m_f > 0) ? m_f - 1 : 0;
      else       m_c = (m_c > 0) ? m_c - 1 : 0;
    end
    if (m) m_ctl = !m_ctl;
    return (of != exp_f()) || (oc != exp_c()) || (octl != m_ctl);
  endfunction

  task automatic ciclos(input int n);
    repeat (n) begin
      @(posedge clk_d);
      @(negedge clk_d);
      if (bus.cambio === 1'b1) cambio_cnt++;
    end
  endtask

  task automatic pulsar(input bit u, input bit d, input bit m, input int hold);
    @(negedge clk_d);
    bus.btn_up = u; bus.btn_down = d; bus.btn_modo = m;
    cambio_cnt = 0;
    ciclos(hold);
    bus.btn_up = 1'b0; bus.btn_down = 1'b0; bus.btn_modo = 1'b0;
    ciclos(12);
  endtask

  task automatic test_reset();
    bus.btn_up = 1'b0; bus.btn_down = 1'b0; bus.btn_modo = 1'b0;
    reset = 1'b1;
    modelo_reset();
    repeat (3) @(negedge clk_d);
    reset = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_d);
      n_cmp++;
      if ({bus.frecuencia, bus.corriente, bus.control, bus.cambio} !== {8'd0, 10'd0, 1'b1, 1'b0}) begin
        n_err++;
        $display("FAIL reset_idle cycle %0d: got f=%0d c=%0d ctl=%b cambio=%b, want f=0 c=0 ctl=1 cambio=0",
                 i, bus.frecuencia, bus.corriente, bus.control, bus.cambio);
      end
    end
  endtask

  task automatic test_latencia();
    for (int p = 0; p < 3; p++) begin
      int lat;
      bit chg;
      @(negedge clk_d);
      bus.btn_up = 1'b1;
      lat = -1;
      cambio_cnt = 0;
      for (int k = 1; k <= 20; k++) begin
        @(posedge clk_d);
        @(negedge clk_d);
        if (k == 6) bus.btn_up = 1'b0;
        if (bus.cambio === 1'b1) begin
          cambio_cnt++;
          if (lat < 0) lat = k;
        end
      end
      ciclos(8);
      chg = modelo(1'b1, 1'b0, 1'b0);
      n_cmp++;
      if (lat != DEB + 3) begin
        n_err++;
        $display("FAIL latency press %0d: got %0d cycles, want %0d", p, lat, DEB + 3);
      end
      n_cmp++;
      if (cambio_cnt != int'(chg)) begin
        n_err++;
        $display("FAIL latency_cambio press %0d: got %0d pulses, want %0d", p, cambio_cnt, chg);
      end
      n_cmp++;
      if (bus.frecuencia !== 8'(exp_f())) begin
        n_err++;
        $display("FAIL latency_frec press %0d: got %0d, want %0d", p, bus.frecuencia, exp_f());
      end
    end
  endtask

  task automatic test_saturacion();
    for (int i = 0; i < 24; i++) begin
      bit u, chg;
      u = (i < 12);
      pulsar(u, !u, 1'b0, $urandom_range(DEB + 1, DEB + 3));
      chg = modelo(u, !u, 1'b0);
      n_cmp++;
      if (bus.frecuencia !== 8'(exp_f()) || cambio_cnt != int'(chg)) begin
        n_err++;
        $display("FAIL saturation step %0d: got f=%0d cambio=%0d, want f=%0d cambio=%0d",
                 i, bus.frecuencia, cambio_cnt, exp_f(), chg);
      end
    end
  endtask

  task automatic test_modo();
    bit chg;
    int f_antes;
    f_antes = exp_f();
    pulsar(1'b0, 1'b0, 1'b1, DEB + 2);
    chg = modelo(1'b0, 1'b0, 1'b1);
    n_cmp++;
    if (bus.control !== m_ctl || cambio_cnt != int'(chg)) begin
      n_err++;
      $display("FAIL mode_toggle: got ctl=%b cambio=%0d, want ctl=%b cambio=%0d", bus.control, cambio_cnt, m_ctl, chg);
    end
    for (int i = 0; i < 21; i++) begin
      pulsar(1'b1, 1'b0, 1'b0, $urandom_range(DEB + 1, DEB + 3));
      chg = modelo(1'b1, 1'b0, 1'b0);
      n_cmp++;
      if (bus.corriente !== 10'(exp_c()) || cambio_cnt != int'(chg)) begin
        n_err++;
        $display("FAIL current_up step %0d: got c=%0d cambio=%0d, want c=%0d cambio=%0d",
                 i, bus.corriente, cambio_cnt, exp_c(), chg);
      end
    end
    n_cmp++;
    if (bus.corriente !== 10'd1000 || bus.frecuencia !== 8'(f_antes)) begin
      n_err++;
      $display("FAIL current_top: got c=%0d f=%0d, want c=1000 f=%0d", bus.corriente, bus.frecuencia, f_antes);
    end
    pulsar(1'b0, 1'b0, 1'b1, DEB + 2);
    void'(modelo(1'b0, 1'b0, 1'b1));
    n_cmp++;
    if (bus.control !== 1'b1) begin
      n_err++;
      $display("FAIL mode_back: got ctl=%b, want 1", bus.control);
    end
  endtask

  task automatic test_glitch();
    @(negedge clk_d);
    bus.btn_up = 1'b1;
    cambio_cnt = 0;
    ciclos(DEB - 2);
    bus.btn_up = 1'b0;
    ciclos(15);
    n_cmp++;
    if (cambio_cnt != 0 || bus.frecuencia !== 8'(exp_f())) begin
      n_err++;
      $display("FAIL glitch: got f=%0d cambio=%0d, want f=%0d cambio=0", bus.frecuencia, cambio_cnt, exp_f());
    end
  endtask

  task automatic test_simultaneo();
    bit chg;
    pulsar(1'b1, 1'b1, 1'b0, DEB + 2);
    chg = modelo(1'b1, 1'b1, 1'b0);
    n_cmp++;
    if (cambio_cnt != int'(chg) || bus.frecuencia !== 8'(exp_f()) || bus.corriente !== 10'(exp_c())) begin
      n_err++;
      $display("FAIL up_down_same: got f=%0d c=%0d cambio=%0d, want f=%0d c=%0d cambio=%0d",
               bus.frecuencia, bus.corriente, cambio_cnt, exp_f(), exp_c(), chg);
    end
  endtask

  task automatic test_modo_sube();
    bit chg;
    pulsar(1'b1, 1'b0, 1'b1, DEB + 2);
    chg = modelo(1'b1, 1'b0, 1'b1);
    n_cmp++;
    if (bus.frecuencia !== 8'(exp_f()) || bus.control !== m_ctl || cambio_cnt != int'(chg)) begin
      n_err++;
      $display("FAIL mode_plus_up: got f=%0d ctl=%b cambio=%0d, want f=%0d ctl=%b cambio=%0d",
               bus.frecuencia, bus.control, cambio_cnt, exp_f(), m_ctl, chg);
    end
  endtask

  task automatic test_aleatorio();
    for (int i = 0; i < 40; i++) begin
      bit u, d, m, chg;
      u = ($urandom_range(0, 2) != 0);
      d = ($urandom_range(0, 3) == 0);
      m = ($urandom_range(0, 4) == 0);
      pulsar(u, d, m, $urandom_range(DEB + 1, DEB + 3));
      chg = modelo(u, d, m);
      n_cmp++;
      if (bus.frecuencia !== 8'(exp_f()) || bus.corriente !== 10'(exp_c()) ||
          bus.control !== m_ctl || cambio_cnt != int'(chg)) begin
        n_err++;
        $display("FAIL random %0d (u=%b d=%b m=%b): got f=%0d c=%0d ctl=%b cambio=%0d, want f=%0d c=%0d ctl=%b cambio=%0d",
                 i, u, d, m, bus.frecuencia, bus.corriente, bus.control, cambio_cnt,
                 exp_f(), exp_c(), m_ctl, chg);
      end
    end
  endtask

`ifdef AUTORREPETICION_EN
  task automatic test_repeticion();
    int pulsos, segundo, f0;
    if (!m_ctl) begin
      pulsar(1'b0, 1'b0, 1'b1, DEB + 2);
      void'(modelo(1'b0, 1'b0, 1'b1));
    end
    while (m_f > 0) begin
      pulsar(1'b0, 1'b1, 1'b0, DEB + 2);
      void'(modelo(1'b0, 1'b1, 1'b0));
    end
    f0 = m_f;
    @(negedge clk_d);
    bus.btn_up = 1'b1;
    pulsos = 0;
    segundo = -1;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk_d);
      @(negedge clk_d);
      if (bus.cambio === 1'b1) begin
        pulsos++;
        if (pulsos == 2) segundo = k;
      end
    end
    bus.btn_up = 1'b0;
    ciclos(12);
    // Steps at 7, then 8 cycles later, then every 4: 7, 15, 19, 23, 27.
    repeat (5) void'(modelo(1'b1, 1'b0, 1'b0));
    n_cmp++;
    if (pulsos != 5 || segundo != DEB + 3 + HOLD) begin
      n_err++;
      $display("FAIL autorepeat_timing: got %0d steps, second at %0d, want 5 steps, second at %0d",
               pulsos, segundo, DEB + 3 + HOLD);
    end
    n_cmp++;
    if (bus.frecuencia !== 8'(exp_f())) begin
      n_err++;
      $display("FAIL autorepeat_value: got f=%0d, want %0d (from idx %0d)", bus.frecuencia, exp_f(), f0);
    end
  endtask
`else
  task automatic test_mantenido();
    bit chg;
    pulsar(1'b1, 1'b0, 1'b0, 60);
    chg = modelo(1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (cambio_cnt != int'(chg) || bus.frecuencia !== 8'(exp_f()) || bus.corriente !== 10'(exp_c())) begin
      n_err++;
      $display("FAIL held_single_step: got f=%0d c=%0d cambio=%0d, want f=%0d c=%0d cambio=%0d",
               bus.frecuencia, bus.corriente, cambio_cnt, exp_f(), exp_c(), chg);
    end
  endtask
`endif

  task automatic test_reset_en_pulsacion();
    if (!m_ctl) begin
      pulsar(1'b0, 1'b0, 1'b1, DEB + 2);
      void'(modelo(1'b0, 1'b0, 1'b1));
    end
    pulsar(1'b1, 1'b0, 1'b0, DEB + 2);
    void'(modelo(1'b1, 1'b0, 1'b0));
    @(negedge clk_d);
    bus.btn_up = 1'b1;
    ciclos(2);
    #2;
    reset = 1'b1;
    modelo_reset();
    #1;
    n_cmp++;
    if ({bus.frecuencia, bus.corriente, bus.control, bus.cambio} !== {8'd0, 10'd0, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL async_reset: got f=%0d c=%0d ctl=%b cambio=%b, want f=0 c=0 ctl=1 cambio=0",
               bus.frecuencia, bus.corriente, bus.control, bus.cambio);
    end
    repeat (3) @(negedge clk_d);
    reset = 1'b0;
    cambio_cnt = 0;
    ciclos(30);
    bus.btn_up = 1'b0;
    ciclos(12);
    n_cmp++;
    if (cambio_cnt != 0 || bus.frecuencia !== 8'd0) begin
      n_err++;
      $display("FAIL held_after_reset: got f=%0d cambio=%0d, want f=0 cambio=0", bus.frecuencia, cambio_cnt);
    end
    pulsar(1'b1, 1'b0, 1'b0, DEB + 2);
    void'(modelo(1'b1, 1'b0, 1'b0));
    n_cmp++;
    if (bus.frecuencia !== 8'(exp_f()) || cambio_cnt != 1) begin
      n_err++;
      $display("FAIL press_after_reset: got f=%0d cambio=%0d, want f=%0d cambio=1", bus.frecuencia, cambio_cnt, exp_f());
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_latencia();
    test_saturacion();
    test_modo();
    test_glitch();
    test_simultaneo();
    test_modo_sube();
    test_aleatorio();
`ifdef AUTORREPETICION_EN
    test_repeticion();
`else
    test_mantenido();
`endif
    test_reset_en_pulsacion();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
